// File: rtl/i2s_adc_receiver_if.sv
// Parallel audio sample bus from the I2S ADC receiver to its consumers.
interface i2s_adc_receiver_if #(
    parameter int unsigned DATA_W = 16
);
    logic [DATA_W-1:0] audio_out_left;
    logic [DATA_W-1:0] audio_out_right;
    logic              sample_valid;
    logic [3:0]        level;

    modport master (
        output audio_out_left,
        output audio_out_right,
        output sample_valid,
        output level
    );

    modport slave (
        input  audio_out_left,
        input  audio_out_right,
        input  sample_valid,
        input  level
    );
endinterface

// File: rtl/i2s_adc_receiver.sv
// Master-mode I2S capture: generates mclk/sck/lrck from a free-running frame
// counter, deserializes left/right samples and tracks a windowed left peak.
module i2s_adc_receiver #(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned PEAK_LOG = 12
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               adc_sdout,
    output logic               adc_mclk,
    output logic               adc_lrck,
    output logic               adc_sck,
    i2s_adc_receiver_if.master aud
);
    localparam int unsigned CNT_W     = 10;
    localparam int unsigned K_W       = 5;
    localparam int unsigned WIN_W     = PEAK_LOG;
    localparam int unsigned LEFT_END  = 16 * DATA_W + 10;
    localparam int unsigned FRAME_END = 512 + LEFT_END;
    localparam logic [DATA_W-1:0] MIN_NEG = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [DATA_W-1:0] MAX_POS = {1'b0, {(DATA_W-1){1'b1}}};

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              sd_q;
    logic [DATA_W-1:0] left_sr_q, left_sr_d;
    logic [DATA_W-1:0] right_sr_q, right_sr_d;
    logic [DATA_W-1:0] left_hold_q, left_hold_d;
    logic [DATA_W-1:0] left_q, left_d;
    logic [DATA_W-1:0] right_q, right_d;
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] peak_q, peak_d;
    logic [WIN_W-1:0]  win_q, win_d;
    logic [3:0]        level_q, level_d;

    logic [K_W-1:0]    k;
    logic              capture;
    logic [DATA_W-1:0] abs_left;
    logic [DATA_W-1:0] peak_max;

    // Clock outputs are direct counter bits, so they are glitch-free.
    assign adc_mclk = cnt_q[1];
    assign adc_sck  = cnt_q[3];
    assign adc_lrck = cnt_q[9];

    assign aud.audio_out_left  = left_q;
    assign aud.audio_out_right = right_q;
    assign aud.sample_valid    = valid_q;
    assign aud.level           = level_q;

    // Frame counter, bit capture, sample hand-off and peak meter next state.
    always_comb begin
        cnt_d       = cnt_q + CNT_W'(1);
        left_sr_d   = left_sr_q;
        right_sr_d  = right_sr_q;
        left_hold_d = left_hold_q;
        left_d      = left_q;
        right_d     = right_q;
        valid_d     = 1'b0;
        peak_d      = peak_q;
        win_d       = win_q;
        level_d     = level_q;

        k       = cnt_q[8:4];
        capture = (cnt_q[3:0] == 4'd9) && (k >= K_W'(1)) && (k <= K_W'(DATA_W));

        if (capture) begin
            if (cnt_q[9]) begin
                right_sr_d = {right_sr_q[DATA_W-2:0], sd_q};
            end else begin
                left_sr_d = {left_sr_q[DATA_W-2:0], sd_q};
            end
        end

        // Left is parked at the end of its half so the frame is delivered atomically.
        if (cnt_q == CNT_W'(LEFT_END)) begin
            left_hold_d = left_sr_q;
        end

        if (cnt_q == CNT_W'(FRAME_END)) begin
            left_d  = left_hold_q;
            right_d = right_sr_q;
            valid_d = 1'b1;
        end

        // Most negative value saturates so the magnitude fits DATA_W-1 bits.
        if (left_q[DATA_W-1]) begin
            abs_left = (left_q == MIN_NEG) ? MAX_POS : DATA_W'(~left_q + DATA_W'(1));
        end else begin
            abs_left = left_q;
        end
        peak_max = (abs_left > peak_q) ? abs_left : peak_q;

        if (valid_q) begin
            win_d = win_q + WIN_W'(1);
            if (win_q == {WIN_W{1'b1}}) begin
                level_d = peak_max[DATA_W-2 -: 4];
                peak_d  = '0;
            end else begin
                peak_d = peak_max;
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= '0;
            sd_q        <= 1'b0;
            left_sr_q   <= '0;
            right_sr_q  <= '0;
            left_hold_q <= '0;
            left_q      <= '0;
            right_q     <= '0;
            valid_q     <= 1'b0;
            peak_q      <= '0;
            win_q       <= '0;
            level_q     <= '0;
        end else begin
            cnt_q       <= cnt_d;
            sd_q        <= adc_sdout;
            left_sr_q   <= left_sr_d;
            right_sr_q  <= right_sr_d;
            left_hold_q <= left_hold_d;
            left_q      <= left_d;
            right_q     <= right_d;
            valid_q     <= valid_d;
            peak_q      <= peak_d;
            win_q       <= win_d;
            level_q     <= level_d;
        end
    end
endmodule

// File: doc/i2s_adc_receiver.md
# i2s_adc_receiver

Master-mode I2S receiver for the line-in ADC on the audio Pmod; it is the capture-side counterpart of the speaker DAC transmitter. It generates mclk, lrck and sck from the 100 MHz system clock and deserializes the ADC's serial data into parallel 16-bit left/right samples with a one-cycle valid strobe. It also produces a 4-bit peak level that the existing scan/display path can show directly.

## Interface
- DATA_W, 16: bits captured per channel, MSB first; legal range 8..24.
- PEAK_LOG, 12: peak-meter window is 2^PEAK_LOG frames.
- clk  in  1  100 MHz system clock.
- rst  in  1  synchronous, active-high reset.
- adc_sdout  in  1  serial data from the ADC.
- adc_mclk  out  1  master clock, clk/4.
- adc_lrck  out  1  word select, clk/1024; 0 = left, 1 = right.
- adc_sck  out  1  bit clock, clk/16 (64 sck per frame).
- audio_out_left  out  DATA_W  last complete left sample, two's complement.
- audio_out_right  out  DATA_W  last complete right sample, two's complement.
- sample_valid  out  1  one-cycle strobe; both audio outputs updated this cycle.
- level  out  4  peak |left| of the last window, 0..15.

## Operation
- Free-running 10-bit counter cnt increments every clk and wraps 1023->0.
  - adc_mclk = cnt[1], adc_sck = cnt[3], adc_lrck = cnt[9]; all are register bits, not decoded logic.
  - Sck index k = cnt[8:4] (0..31 within a half-frame).
- sd_q is adc_sdout registered once per clk.
- Capture:
  - Bit capture occurs on the edge where cnt[3:0]==9 and 1 <= k <= DATA_W.
  - sd_q is shifted into the channel shift register selected by cnt[9], MSB first.
  - k = 0 is the I2S one-bit delay slot and is ignored; k > DATA_W is ignored.
- End of left half: on the edge at cnt == 16*DATA_W+10 (266 for DATA_W=16), the left shift register is copied to a left hold register.
- End of frame: on the edge at cnt == 512+16*DATA_W+10 (778):
  - audio_out_left <= left hold, audio_out_right <= right shift register, sample_valid <= 1.
  - sample_valid clears on the next edge.
- Peak meter:
  - abs_left = |left sample|; -2^(DATA_W-1) saturates to 2^(DATA_W-1)-1.
  - peak <= max(peak, abs_left) at each sample_valid.
  - After 2^PEAK_LOG valid strobes, level <= peak[DATA_W-2 -: 4] and peak is cleared. The strobe that ends the window is included in that window's peak.
- Right samples do not feed the meter.

## Timing
- Reset: cnt = 0, all shift/hold registers 0, peak = 0, window counter 0. Every output is 0: mclk, sck, lrck, audio_out_*, sample_valid, level.
- First edge after rst deasserts: cnt becomes 1. The first frame after reset is captured and delivered: sample_valid is high while cnt == 779.
- Frame period is 1024 clk; sample_valid repeats exactly every 1024 cycles, with no gaps or doubles.
- Latency: last right bit captured at cnt==777 (pre-edge), so outputs change 2 clk later.
- ADC timing: the ADC changes adc_sdout after the sck falling edge (cnt[3:0] 15->0). Capture at cnt[3:0]==9 gives the required setup margin.
- Reset mid-frame: partial bits are discarded. No sample_valid occurs until cnt reaches 779 in the restarted frame. level returns to 0 and the window restarts.
- rst overrides all other activity in the same cycle.

## Test plan
- Reset/clocks:
  - Stimulus: hold rst 3 cycles, then release.
  - Required: all outputs 0 during reset. After release, mclk period 4, sck period 16, lrck period 1024. lrck toggles only on edges where cnt[3:0]==0.
- Basic capture:
  - Stimulus: ADC model sends left 16'hA5C3, right 16'h0F0F.
  - Required: sample_valid one cycle at cnt 779, outputs A5C3/0F0F. Next frame with 8000/7FFF -> outputs exactly those values 1024 cycles later.
- Ignored slots:
  - Stimulus: drive 1 at k=0 and at k=17..31 of both halves, with data 16'h0000.
  - Required: outputs 0000/0000.
- Peak meter, PEAK_LOG=2:
  - Stimulus: left sequence 0x1000, 0x4000, 0xC000, 0x0001.
  - Required: level=8 after the 4th strobe.
  - Next window of 0x8000 x4 -> level=15. Next window of 0xFFFF x4 -> level=0.
- Mid-frame reset:
  - Stimulus: assert rst at cnt=600 for 1 cycle.
  - Required: no strobe in the aborted frame, outputs 0, then a valid frame 779 cycles after release.
- Back-to-back:
  - Stimulus: 50 random frames.
  - Required: every strobe 1024 cycles apart and every sample matching the model.
